// File: rtl/tb_memory_regbus_mp_pkg.sv
// Shared types and helpers for the multi-port regbus memory model.
// The request/response structs mirror the reg_a48_d32 regbus types of the
// Occamy harness so this slice stays self-contained.
package tb_memory_regbus_mp_pkg;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_a48_d32_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Saturating increment for the 16-bit error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/tb_memory_regbus_rr_arb.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// after the pointer, wrapping from NumPorts-1 back to 0.
module tb_memory_regbus_rr_arb #(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] valid_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic                gnt_valid_o,
    output logic [IdxW-1:0]     gnt_idx_o
);

    int unsigned     cand_s;
    logic [IdxW-1:0] cand_idx_s;

    // Scan from the pointer upward; the first valid candidate wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand_s      = 32'd0;
        cand_idx_s  = '0;
        for (int unsigned off = 0; off < NumPorts; off++) begin
            cand_s     = 32'(ptr_i) + off;
            cand_s     = (cand_s >= NumPorts) ? (cand_s - NumPorts) : cand_s;
            cand_idx_s = IdxW'(cand_s);
            if (!gnt_valid_o && valid_i[cand_idx_s]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_idx_s;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/tb_memory_regbus_mp.sv
// Multi-port regbus memory: N masters share one word array through a
// round-robin arbiter, with programmable latency, byte strobes and
// address-range error responses.
module tb_memory_regbus_mp
    import tb_memory_regbus_mp_pkg::*;
#(
    parameter int unsigned          NumPorts  = 4,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = {AddrWidth{1'b0}},
    parameter int unsigned          LatWidth  = 4,
    parameter type                  req_t     = reg_a48_d32_req_t,
    parameter type                  rsp_t     = reg_a48_d32_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  req_t                req_i [NumPorts],
    output rsp_t                rsp_o [NumPorts],
    input  logic [LatWidth-1:0] lat_i,
    output logic                busy_o,
    output logic [15:0]         err_cnt_o
);

    localparam int unsigned IdxW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned WordShift = $clog2(DataWidth / 8);
    localparam int unsigned MemIdxW   = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned StrbW     = DataWidth / 8;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       gnt_q, gnt_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [LatWidth-1:0]   cnt_q, cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  busy_q;
    logic [DataWidth-1:0]  mem_q [NumWords];

    logic [NumPorts-1:0]   valid_s;
    logic                  arb_valid_s;
    logic [IdxW-1:0]       arb_idx_s;
    logic [IdxW-1:0]       ptr_next_s;
    req_t                  cur_req_s;
    logic [AddrWidth-1:0]  off_s;
    logic [AddrWidth-1:0]  word_idx_s;
    logic                  in_range_s;
    logic [MemIdxW-1:0]    mem_idx_s;
    logic                  we_s;
    rsp_t                  rsp_s [NumPorts];

    // Gather the per-port valid bits for the arbiter.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            valid_s[p] = req_i[p].valid;
        end
    end

    tb_memory_regbus_rr_arb #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) i_arb (
        .valid_i     (valid_s),
        .ptr_i       (ptr_q),
        .gnt_valid_o (arb_valid_s),
        .gnt_idx_o   (arb_idx_s)
    );

    // Request fields are taken live from the granted port; decode its address.
    always_comb begin
        cur_req_s  = req_i[gnt_q];
        off_s      = cur_req_s.addr - BaseAddr;
        word_idx_s = off_s >> WordShift;
        in_range_s = (cur_req_s.addr >= BaseAddr) && (word_idx_s < AddrWidth'(NumWords));
        mem_idx_s  = word_idx_s[MemIdxW-1:0];
        ptr_next_s = (gnt_q == IdxW'(NumPorts - 1)) ? {IdxW{1'b0}} : (gnt_q + IdxW'(1));
    end

    // Next-state logic and response generation for IDLE/WAIT/RESP.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        err_cnt_d = err_cnt_q;
        we_s      = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rsp_s[p] = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    gnt_d   = arb_idx_s;
                    cnt_d   = lat_i;
                    state_d = (lat_i != {LatWidth{1'b0}}) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A master dropping valid aborts the transaction silently.
                if (!cur_req_s.valid) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_next_s;
                end else if (cnt_q == LatWidth'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - LatWidth'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ptr_d   = ptr_next_s;
                if (cur_req_s.valid) begin
                    rsp_s[gnt_q].ready = 1'b1;
                    if (in_range_s) begin
                        we_s               = cur_req_s.write;
                        rsp_s[gnt_q].rdata = cur_req_s.write ? '0 : mem_q[mem_idx_s];
                    end else begin
                        rsp_s[gnt_q].error = 1'b1;
                        err_cnt_d          = sat_inc16(err_cnt_q);
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; busy tracks "not returning to IDLE".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= 16'h0000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Word array: cleared on reset, byte-lane writes committed at the RESP edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned w = 0; w < NumWords; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we_s) begin
            for (int unsigned b = 0; b < StrbW; b++) begin
                if (cur_req_s.wstrb[b]) begin
                    mem_q[mem_idx_s][8*b +: 8] <= cur_req_s.wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_o     = rsp_s;
    assign busy_o    = busy_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_tb_memory_regbus_mp.sv
// Self-checking bench for tb_memory_regbus_mp: a transaction-timeline model
// checks every cycle, directed scenarios pin literal expectations.
module tb_tb_memory_regbus_mp;
    import tb_memory_regbus_mp_pkg::*;

    localparam int NP = 4;
    localparam int NW = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    reg_a48_d32_req_t req [NP];
    reg_a48_d32_rsp_t rsp [NP];
    logic [3:0]       lat;
    logic             busy;
    logic [15:0]      err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    tb_memory_regbus_mp dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .rsp_o     (rsp),
        .lat_i     (lat),
        .busy_o    (busy),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (transaction timeline) ----------------
    logic [31:0] m_mem [NW];
    bit          m_inf;
    int          m_g, m_gcyc, m_rcyc, m_rr, cand;
    logic [15:0] m_err;
    bit          e_busy;
    logic [15:0] e_errcnt;
    bit          e_rdy [NP];
    bit          e_err [NP];
    bit          e_rdchk [NP];
    logic [31:0] e_rd [NP];
    logic [47:0] m_widx;

    initial begin
        m_inf = 0; m_rr = 0; m_err = 16'h0; m_g = 0; m_gcyc = 0; m_rcyc = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                e_rdy[p] = 0; e_err[p] = 0; e_rd[p] = 32'h0; e_rdchk[p] = 1;
            end
            if (!rst_n) begin
                for (int i = 0; i < NW; i++) m_mem[i] = 32'h0;
                m_inf = 0; m_rr = 0; m_err = 16'h0;
                e_busy = 0; e_errcnt = 16'h0;
            end else begin
                if (!m_inf) begin
                    for (int off = 0; off < NP; off++) begin
                        cand = (m_rr + off) % NP;
                        if (!m_inf && req[cand].valid) begin
                            m_inf = 1; m_g = cand; m_gcyc = cyc; m_rcyc = cyc + 1 + int'(lat);
                        end
                    end
                end
                e_busy   = m_inf && (cyc > m_gcyc);
                e_errcnt = m_err;
                if (m_inf && (cyc > m_gcyc)) begin
                    if (!req[m_g].valid) begin
                        m_inf = 0; m_rr = (m_g + 1) % NP;
                    end else if (cyc == m_rcyc) begin
                        m_widx = req[m_g].addr >> 2;
                        e_rdy[m_g] = 1;
                        if (m_widx >= 48'(NW)) begin
                            e_err[m_g] = 1;
                            m_err = (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
                        end else if (req[m_g].write) begin
                            e_rdchk[m_g] = 0;
                            for (int b = 0; b < 4; b++)
                                if (req[m_g].wstrb[b]) m_mem[m_widx[9:0]][8*b +: 8] = req[m_g].wdata[8*b +: 8];
                        end else begin
                            e_rd[m_g] = m_mem[m_widx[9:0]];
                        end
                        m_inf = 0; m_rr = (m_g + 1) % NP;
                    end
                end
            end
            chk("model_busy", 64'(busy), 64'(e_busy));
            chk("model_err_cnt", 64'(err_cnt), 64'(e_errcnt));
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("model_ready_p%0d", p), 64'(rsp[p].ready), 64'(e_rdy[p]));
                chk($sformatf("model_error_p%0d", p), 64'(rsp[p].error), 64'(e_err[p]));
                if (e_rdchk[p]) chk($sformatf("model_rdata_p%0d", p), 64'(rsp[p].rdata), 64'(e_rd[p]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          kr, nb;
    int          bp [8];
    int          bc [8];
    int          bn;
    bit          seen;

    task automatic txn(input int p, input logic [47:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [3:0] l,
                       output logic [31:0] rdo, output logic ero, output int kro, output int nbo);
        rdo = 32'h0; ero = 1'b0; kro = -1; nbo = 0;
        @(posedge clk); #1;
        req[p] = '{addr: a, write: w, wdata: d, wstrb: s, valid: 1'b1};
        lat = l;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nbo++;
            if (rsp[p].ready) begin
                rdo = rsp[p].rdata; ero = rsp[p].error; kro = k;
                break;
            end
            @(posedge clk); #1;
            lat = 4'hF;
        end
        if (kro < 0) begin
            n_checks++; n_fail++;
            $display("FAIL txn_timeout port=%0d actual=no_ready required=ready", p);
        end
        @(posedge clk); #1;
        req[p].valid = 1'b0;
    endtask

    task automatic burst(input logic [3:0] mask, input int n);
        bn = 0;
        @(posedge clk); #1;
        lat = 4'd0;
        for (int p = 0; p < NP; p++)
            if (mask[p]) req[p] = '{addr: 48'h100 + 48'(4 * p), write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        for (int k = 0; k < 60 && bn < n; k++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                if (rsp[p].ready && bn < 8) begin bp[bn] = p; bc[bn] = k; bn++; end
            if (bn < n) begin @(posedge clk); #1; end
        end
        if (bn < n) begin
            n_checks++; n_fail++;
            $display("FAIL burst_timeout actual=%0d required=%0d", bn, n);
        end
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) req[p].valid = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) req[p] = '0;
        lat = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_ready_p0", 64'(rsp[0].ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write / read-back, one-cycle latency.
        txn(0, 48'h10, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, rd, er, kr, nb);
        chk("wr_latency", 64'(kr), 64'd1);
        txn(0, 48'h10, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("rd_latency", 64'(kr), 64'd1);
        chk("rd_data", 64'(rd), 64'hDEADBEEF);
        chk("rd_error", 64'(er), 64'd0);

        // Byte strobes, including an all-zero strobe.
        txn(1, 48'h20, 1'b1, 32'h11223344, 4'hF, 4'd0, rd, er, kr, nb);
        txn(1, 48'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 4'd0, rd, er, kr, nb);
        txn(1, 48'h20, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("strobe_merge", 64'(rd), 64'h11BB33DD);
        txn(1, 48'h20, 1'b1, 32'hFFFFFFFF, 4'h0, 4'd0, rd, er, kr, nb);
        chk("strobe_zero_error", 64'(er), 64'd0);
        txn(1, 48'h20, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("strobe_zero_nochange", 64'(rd), 64'h11BB33DD);

        // Latency 5 (lat_i is scrambled after grant inside txn).
        txn(2, 48'h10, 1'b0, 32'h0, 4'h0, 4'd5, rd, er, kr, nb);
        chk("lat5_ready_cycle", 64'(kr), 64'd6);
        chk("lat5_busy_cycles", 64'(nb), 64'd6);
        chk("lat5_rdata", 64'(rd), 64'hDEADBEEF);

        // Move the pointer to 0, then all four ports request together.
        txn(3, 48'h24, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        burst(4'hF, 5);
        chk("arb_order0", 64'(bp[0]), 64'd0);
        chk("arb_order1", 64'(bp[1]), 64'd1);
        chk("arb_order2", 64'(bp[2]), 64'd2);
        chk("arb_order3", 64'(bp[3]), 64'd3);
        chk("arb_order4", 64'(bp[4]), 64'd0);
        chk("arb_first_ready", 64'(bc[0]), 64'd1);
        chk("arb_period", 64'(bc[4] - bc[0]), 64'd8);

        // Address range: first word past the end and the last valid word.
        txn(0, 48'h1000, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("range_rd_error", 64'(er), 64'd1);
        chk("range_rd_rdata", 64'(rd), 64'd0);
        @(negedge clk);
        chk("range_err_cnt1", 64'(err_cnt), 64'd1);
        txn(0, 48'h1000, 1'b1, 32'hCAFEF00D, 4'hF, 4'd0, rd, er, kr, nb);
        chk("range_wr_error", 64'(er), 64'd1);
        @(negedge clk);
        chk("range_err_cnt2", 64'(err_cnt), 64'd2);
        txn(0, 48'h0, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("range_wr_no_alias", 64'(rd), 64'd0);
        txn(0, 48'hFFC, 1'b1, 32'hA5A55A5A, 4'hF, 4'd0, rd, er, kr, nb);
        txn(0, 48'hFFC, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("last_word_rdata", 64'(rd), 64'hA5A55A5A);
        chk("last_word_error", 64'(er), 64'd0);

        // Abort: port 2 drops valid during WAIT.
        @(posedge clk); #1;
        req[2] = '{addr: 48'h10, write: 1'b1, wdata: 32'h12345678, wstrb: 4'hF, valid: 1'b1};
        lat = 4'd3;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp[2].ready) seen = 1;
            @(posedge clk); #1;
        end
        req[2].valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp[2].ready) seen = 1;
        end
        chk("abort_no_ready", 64'(seen), 64'd0);
        chk("abort_err_cnt", 64'(err_cnt), 64'd2);
        burst(4'b1001, 1);
        chk("abort_next_grant", 64'(bp[0]), 64'd3);
        txn(0, 48'h10, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("abort_mem_unchanged", 64'(rd), 64'hDEADBEEF);

        // Reset in the middle of WAIT.
        @(posedge clk); #1;
        req[1] = '{addr: 48'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        lat = 4'd4;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midwait_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req[1].valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_ready_p1", 64'(rsp[1].ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(0, 48'h10, 1'b0, 32'h0, 4'h0, 4'd0, rd, er, kr, nb);
        chk("rst_cleared_0x10", 64'(rd), 64'd0);
        txn(1, 48'h20, 1'b0, 32'h0, 4'h0, 4'd2, rd, er, kr, nb);
        chk("rst_cleared_0x20", 64'(rd), 64'd0);
        chk("lat2_ready_cycle", 64'(kr), 64'd3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
